// File: rtl/bramac_pkg.sv
// Shared definitions for the BrAMAC instruction sequencer: instruction field
// layout, FSM state type and the instruction packing helper.
package bramac_pkg;

  localparam int unsigned DWIDTH   = 40;
  localparam int unsigned CORE_W   = 25;

  localparam int unsigned START_BIT = 23;
  localparam int unsigned DONE_BIT  = 22;
  localparam int unsigned COPY_BIT  = 21;
  localparam int unsigned MODE_LSB  = 19;
  localparam int unsigned ROW_LSB   = 12;
  localparam int unsigned COL1_LSB  = 10;
  localparam int unsigned COL2_LSB  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Bit 24 (fsm_2sa reset) is never driven by this sequencer.
  function automatic logic [CORE_W-1:0] pack_inst(
    input logic       start,
    input logic       done,
    input logic       copy_en,
    input logic [1:0] mode,
    input logic [6:0] row,
    input logic [1:0] col_1,
    input logic [1:0] col_2,
    input logic [7:0] in_byte
  );
    logic [CORE_W-1:0] w;
    w                 = '0;
    w[START_BIT]      = start;
    w[DONE_BIT]       = done;
    w[COPY_BIT]       = copy_en;
    w[MODE_LSB +: 2]  = mode;
    w[ROW_LSB +: 7]   = row;
    w[COL1_LSB +: 2]  = col_1;
    w[COL2_LSB +: 2]  = col_2;
    w[7:0]            = in_byte;
    return w;
  endfunction

endpackage

// File: rtl/bramac_inst_sequencer.sv
// Job-level instruction generator for fsm_2sa: turns one MAC command plus an
// operand stream into start / paired copy / done instruction words.
module bramac_inst_sequencer #(
  parameter int unsigned DWIDTH       = bramac_pkg::DWIDTH,
  parameter int unsigned WAIT_CYCLES  = 5,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned DONE_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              reset_bram_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [6:0]        cmd_row_base,
  input  logic [5:0]        cmd_num_pairs,
  input  logic [1:0]        cmd_col_1,
  input  logic [1:0]        cmd_col_2,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic [DWIDTH-1:0] inst,
  output logic              busy,
  output logic              job_done
);
  import bramac_pkg::*;

  localparam int unsigned CNT_W = 16;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        k_q, k_d;
  logic [5:0]        num_pairs_q, num_pairs_d;
  logic [6:0]        row_base_q, row_base_d;
  logic [1:0]        mode_q, mode_d;
  logic [1:0]        col_1_q, col_1_d;
  logic [1:0]        col_2_q, col_2_d;
  logic [DWIDTH-1:0] inst_q, inst_d;
  logic              job_done_q, job_done_d;
  logic [DWIDTH-1:0] nop_word;
  logic [6:0]        row_a, row_b;

  // Every output word is decided one cycle ahead of the cycle it is visible in.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    num_pairs_d = num_pairs_q;
    row_base_d  = row_base_q;
    mode_d      = mode_q;
    col_1_d     = col_1_q;
    col_2_d     = col_2_q;
    inst_d      = inst_q;
    job_done_d  = 1'b0;

    nop_word            = inst_q;
    nop_word[START_BIT] = 1'b0;
    nop_word[DONE_BIT]  = 1'b0;
    nop_word[COPY_BIT]  = 1'b0;

    row_a = row_base_q + {k_q, 1'b0};
    row_b = row_a + 7'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          mode_d      = cmd_mode;
          row_base_d  = cmd_row_base;
          num_pairs_d = cmd_num_pairs;
          col_1_d     = cmd_col_1;
          col_2_d     = cmd_col_2;
          k_d         = '0;
          cnt_d       = '0;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        inst_d = DWIDTH'(pack_inst(1'b1, 1'b0, 1'b0, mode_q, 7'd0,
                                   col_1_q, col_2_q, 8'd0));
        if (cnt_q == CNT_W'(START_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = (num_pairs_q != '0) ? ST_LOAD_A : ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOAD_A: begin
        if (in_valid) begin
          inst_d  = DWIDTH'(pack_inst(1'b0, 1'b0, 1'b1, mode_q, row_a,
                                      col_1_q, col_2_q, in_data));
          state_d = ST_LOAD_B;
        end else begin
          inst_d = nop_word;
        end
      end
      ST_LOAD_B: begin
        if (in_valid) begin
          inst_d = DWIDTH'(pack_inst(1'b0, 1'b0, 1'b1, mode_q, row_b,
                                     col_1_q, col_2_q, in_data));
          k_d    = k_q + 6'd1;
          cnt_d  = '0;
          if (WAIT_CYCLES != 0) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ((k_q + 6'd1) < num_pairs_q) ? ST_LOAD_A : ST_DONE;
          end
        end else begin
          inst_d = nop_word;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = (k_q < num_pairs_q) ? ST_LOAD_A : ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        inst_d = DWIDTH'(pack_inst(1'b0, 1'b1, 1'b0, mode_q, 7'd0,
                                   col_1_q, 2'b00, 8'd0));
        if (cnt_q == CNT_W'(DONE_CYCLES - 1)) begin
          cnt_d      = '0;
          job_done_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_bram_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      num_pairs_q <= '0;
      row_base_q  <= '0;
      mode_q      <= '0;
      col_1_q     <= '0;
      col_2_q     <= '0;
      inst_q      <= '0;
      job_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      num_pairs_q <= num_pairs_d;
      row_base_q  <= row_base_d;
      mode_q      <= mode_d;
      col_1_q     <= col_1_d;
      col_2_q     <= col_2_d;
      inst_q      <= inst_d;
      job_done_q  <= job_done_d;
    end
  end

  assign inst      = inst_q;
  assign job_done  = job_done_q;
  assign busy      = (state_q != ST_IDLE);
  assign cmd_ready = (state_q == ST_IDLE);
  assign in_ready  = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);

endmodule

// File: tb/tb_bramac_inst_sequencer.sv
// Self-checking bench for bramac_inst_sequencer: each job's expected word
// stream is built from the field/timing rules, then replayed cycle by cycle.
module tb_bramac_inst_sequencer;

  localparam int unsigned DW     = 40;
  localparam int unsigned WAITC  = 5;
  localparam int unsigned STARTC = 2;
  localparam int unsigned DONEC  = 2;

  logic          clk = 1'b0;
  logic          reset_bram_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_mode;
  logic [6:0]    cmd_row_base;
  logic [5:0]    cmd_num_pairs;
  logic [1:0]    cmd_col_1;
  logic [1:0]    cmd_col_2;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic [DW-1:0] inst;
  logic          busy;
  logic          job_done;

  bramac_inst_sequencer #(
    .DWIDTH      (DW),
    .WAIT_CYCLES (WAITC),
    .START_CYCLES(STARTC),
    .DONE_CYCLES (DONEC)
  ) dut (
    .clk          (clk),
    .reset_bram_n (reset_bram_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_mode     (cmd_mode),
    .cmd_row_base (cmd_row_base),
    .cmd_num_pairs(cmd_num_pairs),
    .cmd_col_1    (cmd_col_1),
    .cmd_col_2    (cmd_col_2),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .inst         (inst),
    .busy         (busy),
    .job_done     (job_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_word(input logic st, input logic dn, input logic cp,
                                            input logic [1:0] md, input logic [6:0] row,
                                            input logic [1:0] c1, input logic [1:0] c2,
                                            input logic [7:0] d);
    logic [DW-1:0] w;
    w = '0;
    w[24:0] = {1'b0, st, dn, cp, md, row, c1, c2, d};
    return w;
  endfunction

  function automatic logic [DW-1:0] mk_nop(input logic [DW-1:0] prev);
    logic [DW-1:0] w;
    w = prev;
    w[23:21] = 3'b000;
    return w;
  endfunction

  // Expected stream; kind 0 = word decided outside LOAD, 1 = operand issue, 2 = stall NOP
  logic [DW-1:0] exp_w[$];
  int            exp_k[$];
  logic [7:0]    ops[$];
  int            stalls[$];

  task automatic build(input logic [1:0] md, input logic [6:0] base, input int np,
                       input logic [1:0] c1, input logic [1:0] c2);
    logic [6:0]    row;
    logic [DW-1:0] last;
    exp_w.delete();
    exp_k.delete();
    for (int i = 0; i < int'(STARTC); i++) begin
      exp_w.push_back(mk_word(1'b1, 1'b0, 1'b0, md, 7'd0, c1, c2, 8'd0));
      exp_k.push_back(0);
    end
    for (int p = 0; p < np; p++) begin
      for (int h = 0; h < 2; h++) begin
        row = base + 7'(2 * p + h);
        for (int s = 0; s < stalls[2*p+h]; s++) begin
          last = exp_w[exp_w.size()-1];
          exp_w.push_back(mk_nop(last));
          exp_k.push_back(2);
        end
        exp_w.push_back(mk_word(1'b0, 1'b0, 1'b1, md, row, c1, c2, ops[2*p+h]));
        exp_k.push_back(1);
        if (h == 1) begin
          for (int i = 0; i < int'(WAITC); i++) begin
            last = exp_w[exp_w.size()-1];
            exp_w.push_back(last);
            exp_k.push_back(0);
          end
        end
      end
    end
    for (int i = 0; i < int'(DONEC); i++) begin
      exp_w.push_back(mk_word(1'b0, 1'b1, 1'b0, md, 7'd0, c1, 2'b00, 8'd0));
      exp_k.push_back(0);
    end
  endtask

  task automatic rand_ops(input int np, input int max_stall);
    ops.delete();
    stalls.delete();
    for (int i = 0; i < 2 * np; i++) begin
      ops.push_back(8'($urandom));
      stalls.push_back(int'($urandom_range(0, max_stall)));
    end
  endtask

  // Entered and left just after a falling edge with the DUT idle.
  // abort_at >= 0 pulls reset during the state cycle that decides that word.
  task automatic run_job(input logic [1:0] md, input logic [6:0] base, input int np,
                         input logic [1:0] c1, input logic [1:0] c2, input int abort_at);
    logic [DW-1:0] w;
    int            len;
    build(md, base, np, c1, c2);
    len = exp_w.size();
    check_eq("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    check_eq("busy_idle", 64'(busy), 64'd0);
    cmd_valid     = 1'b1;
    cmd_mode      = md;
    cmd_row_base  = base;
    cmd_num_pairs = 6'(np);
    cmd_col_1     = c1;
    cmd_col_2     = c2;
    @(negedge clk);
    for (int j = 0; j < len; j++) begin
      w = exp_w[j];
      if (j == abort_at) begin
        reset_bram_n = 1'b0;
        cmd_valid    = 1'b0;
        in_valid     = 1'($urandom);
        @(negedge clk);
        check_eq("rst_inst", 64'(inst), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_job_done", 64'(job_done), 64'd0);
        reset_bram_n = 1'b1;
        in_valid     = 1'b0;
        return;
      end
      cmd_valid     = 1'($urandom);
      cmd_mode      = 2'($urandom);
      cmd_row_base  = 7'($urandom);
      cmd_num_pairs = 6'($urandom);
      cmd_col_1     = 2'($urandom);
      cmd_col_2     = 2'($urandom);
      case (exp_k[j])
        1:       begin in_valid = 1'b1; in_data = w[7:0]; end
        2:       begin in_valid = 1'b0; in_data = 8'($urandom); end
        default: begin in_valid = 1'($urandom); in_data = 8'($urandom); end
      endcase
      check_eq("in_ready", 64'(in_ready), 64'(exp_k[j] != 0));
      check_eq("busy", 64'(busy), 64'd1);
      check_eq("cmd_ready_busy", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      check_eq("inst", 64'(inst), 64'(w));
      check_eq("job_done", 64'(job_done), 64'(j == len - 1));
    end
    cmd_valid = 1'b0;
    in_valid  = 1'($urandom);
    check_eq("busy_end", 64'(busy), 64'd0);
    check_eq("cmd_ready_end", 64'(cmd_ready), 64'd1);
    check_eq("in_ready_end", 64'(in_ready), 64'd0);
    @(negedge clk);
    check_eq("inst_hold", 64'(inst), 64'(exp_w[len-1]));
    check_eq("job_done_once", 64'(job_done), 64'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [7:0] plan_ops [10];
    plan_ops = '{8'h50, 8'h30, 8'hA0, 8'hC0, 8'hA0, 8'h30, 8'hA0, 8'hF0, 8'h50, 8'h00};

    reset_bram_n  = 1'b0;
    cmd_valid     = 1'b1;
    cmd_mode      = '0;
    cmd_row_base  = '0;
    cmd_num_pairs = 6'd3;
    cmd_col_1     = '0;
    cmd_col_2     = '0;
    in_valid      = 1'b1;
    in_data       = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_inst", 64'(inst), 64'd0);
    check_eq("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_in_ready", 64'(in_ready), 64'd0);
    check_eq("reset_job_done", 64'(job_done), 64'd0);
    reset_bram_n = 1'b1;
    cmd_valid    = 1'b0;
    in_valid     = 1'b0;
    @(negedge clk);

    // Five pairs, no stalls: 2 + 35 + 2 words
    ops.delete();
    stalls.delete();
    for (int unsigned i = 0; i < 10; i++) begin
      ops.push_back(plan_ops[i]);
      stalls.push_back(0);
    end
    run_job(2'b10, 7'd0, 5, 2'b00, 2'b01, -1);

    // Same job, operand 3 (pair 1 second weight) held off for 3 cycles
    stalls[3] = 3;
    run_job(2'b10, 7'd0, 5, 2'b00, 2'b01, -1);

    // Empty job
    rand_ops(0, 0);
    run_job(2'b01, 7'd55, 0, 2'b11, 2'b10, -1);

    // Row wrap
    rand_ops(2, 0);
    run_job(2'b11, 7'd126, 2, 2'b01, 2'b11, -1);

    // Reset in WAIT, then a job right after
    rand_ops(3, 0);
    run_job(2'b10, 7'd20, 3, 2'b10, 2'b01, int'(STARTC) + 3);
    rand_ops(2, 2);
    run_job(2'b01, 7'd100, 2, 2'b11, 2'b00, -1);

    // Maximum pair count
    rand_ops(63, 0);
    run_job(2'b00, 7'd90, 63, 2'b10, 2'b11, -1);

    for (int unsigned t = 0; t < 25; t++) begin
      int np;
      np = int'($urandom_range(0, 6));
      rand_ops(np, 3);
      run_job(2'($urandom), 7'($urandom), np, 2'($urandom), 2'($urandom), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bramac_inst_sequencer.md
Name: bramac_inst_sequencer

Overview:
- Upstream instruction generator for the BrAMAC 2-SA control FSM (fsm_2sa).
- Accepts one MAC job command: mode, base BRAM row, column pair and number of weight pairs.
- Pulls 8-bit input operands from an input stream with a valid/ready handshake.
- Emits the 40-bit instruction stream with the timing fsm_2sa needs: start, paired copy instructions separated by compute gaps, then done.

Parameters:
- DWIDTH, 40, instruction width; must be at least 25.
- WAIT_CYCLES, 5, extra cycles the LOAD_B word is held after its issue cycle, so the pair period is 2+WAIT_CYCLES.
- START_CYCLES, 2, cycles the start word is held.
- DONE_CYCLES, 2, cycles the done word is held.

Ports:
- clk  in  1  clock; all logic is on its rising edge.
- reset_bram_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  job command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_mode  in  2  mode field copied into inst[20:19].
- cmd_row_base  in  7  BRAM row address of the first W1.
- cmd_num_pairs  in  6  number of W1/W2 pairs, 0..63.
- cmd_col_1  in  2  copied into inst[11:10].
- cmd_col_2  in  2  copied into inst[9:8].
- in_valid  in  1  input operand valid.
- in_ready  out  1  operand accept.
- in_data  in  8  input operand.
- inst  out  DWIDTH  instruction to fsm_2sa.
- busy  out  1  high whenever state is not IDLE.
- job_done  out  1  one-cycle pulse at the end of a job.

Behaviour:
- Instruction fields:
  - [DWIDTH-1:25] zero
  - 24 reset (always 0)
  - 23 start
  - 22 done
  - 21 copy_en
  - 20:19 mode
  - 18:12 row
  - 11:10 col_1
  - 9:8 col_2
  - 7:0 input
- inst is a registered output. Mode, col_1 and col_2 are latched at command accept and appear in every word of the job.
- Reset (reset_bram_n=0 at a clock edge):
  - state goes to IDLE; inst=0, job_done=0, busy=0, pair counter=0.
  - After reset, cmd_ready=1 and in_ready=0.
  - Reset mid-job abandons the job immediately; no done word is issued.
- States: IDLE, START, LOAD_A, LOAD_B, WAIT, DONE.
- IDLE:
  - inst holds its last value (0 after reset).
  - cmd_valid & cmd_ready latches the command, clears the pair counter k, and enters START.
- START:
  - inst = start=1, row=0, input=0, copy_en=0, held START_CYCLES cycles.
  - Exits to LOAD_A if num_pairs>0, otherwise to DONE.
- LOAD_A:
  - in_ready=1.
  - On in_valid: inst = copy_en=1, row=row_base+2k, input=in_data; go to LOAD_B.
  - Without in_valid: emit NOP (all control bits 0, row and input unchanged) and stay.
- LOAD_B:
  - Same handshake as LOAD_A, with row=row_base+2k+1.
  - On accept: increment k and go to WAIT.
  - Stall: NOP.
- WAIT:
  - inst holds the LOAD_B word unchanged for WAIT_CYCLES cycles.
  - Exits to LOAD_A if k<num_pairs, otherwise to DONE.
- DONE:
  - inst = done=1, copy_en=0, row=0, col_2=0, input=0, held DONE_CYCLES cycles.
  - job_done pulses in the final DONE cycle; then go to IDLE.
- in_ready is asserted only in LOAD_A/LOAD_B; in_ready is a registered-state decode, so there is no combinational path from in_valid.
- Row arithmetic is 7-bit and wraps modulo 128; no error flag.
- A cmd_valid that arrives while busy is not accepted (cmd_ready=0).
- With no stalls, a job of N pairs occupies START_CYCLES + N*(2+WAIT_CYCLES) + DONE_CYCLES cycles.

Decomposition:
- Package bramac_pkg holds:
  - DWIDTH;
  - field bit-position localparams (START_BIT=23, DONE_BIT=22, COPY_BIT=21, MODE_LSB=19, ROW_LSB=12, COL1_LSB=10, COL2_LSB=8);
  - the state enum typedef;
  - a function pack_inst(start, done, copy_en, mode, row, col_1, col_2, input).
- No sub-module; a single FSM plus counters.

Test Plan:
- Reset while idle: hold reset_bram_n=0 for 2 cycles -> inst=0, cmd_ready=1, busy=0, in_ready=0.
- Mode/column latching and start: cmd mode=2'b10, base=0, col 00/01, pairs=5, with in_valid always high, inputs 0x50,0x30,0xA0,0xC0,0xA0,0x30,0xA0,0xF0,0x50,0x00 ->
  - 2 start cycles;
  - then the pattern W1 row 0 / 0x50 (1 cycle), W2 row 1 / 0x30 (6 cycles), repeated through rows 8/9;
  - every word has mode=10, col_1=00, col_2=01.
- Done and cycle count for the same job -> 2 done cycles; job_done pulses once; total length is 2+35+2 = 39 cycles.
- Input stall: drop in_valid for 3 cycles in LOAD_B of pair 1 -> 3 NOP words (copy_en=0); row 3 is then issued once; no duplicate copy.
- pairs=0 -> start×2, done×2, job_done pulse, in_ready never asserted.
- Wrap and mid-job reset:
  - base=126, pairs=2 -> rows 126,127,0,1.
  - Reset in WAIT -> next cycle inst=0 and state IDLE; a new command is accepted right after reset.
